// File: rtl/seq_mag_cmp.sv
// -----------------------------------------------------------------------------
// seq_mag_cmp
//
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands DIGIT bits
// per clock, most significant digit first, so no WIDTH-bit combinational
// compare path exists. Signed operands are handled by flipping the sign bit of
// both operands at latch time (offset binary), which turns the signed compare
// into an unsigned one.
//
// Parameters:
//   WIDTH      - operand width, a multiple of DIGIT and at least DIGIT
//   DIGIT      - bits compared per cycle (NDIG = WIDTH/DIGIT digits)
//   EARLY_EXIT - 1: stop at the first unequal digit; 0: always NDIG cycles
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   start       - compare request, accepted only in IDLE
//   signed_mode - 1: a/b are two's complement (sampled with start)
//   a, b        - operands (sampled with start)
//   busy        - high while digits are being compared
//   done        - one-cycle pulse, x valid from this cycle on
//   x           - one-hot result {lt, eq, gt}; 3'b000 = no valid result
// -----------------------------------------------------------------------------
module seq_mag_cmp #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DIGIT      = 4,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [2:0]       x
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   localparam logic [2:0] X_GT = 3'b001;
   localparam logic [2:0] X_EQ = 3'b010;
   localparam logic [2:0] X_LT = 3'b100;

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             diff_q, diff_d;     // a difference has already been seen
   logic             gt_rec_q, gt_rec_d; // direction of that first difference
   logic [2:0]       x_q, x_d;

   logic [DIGIT-1:0] slice_a, slice_b;
   logic             slice_ne, slice_gt;
   logic             any_diff, first_gt;
   logic [WIDTH-1:0] sign_flip;

   // Top digit of each shift register is the one under comparison this cycle.
   assign slice_a  = a_q[WIDTH-1 -: DIGIT];
   assign slice_b  = b_q[WIDTH-1 -: DIGIT];
   assign slice_ne = (slice_a != slice_b);
   assign slice_gt = (slice_a > slice_b);

   // Outcome if the compare ends this cycle: an earlier recorded difference
   // always wins over the current digit.
   assign any_diff = diff_q | slice_ne;
   assign first_gt = diff_q ? gt_rec_q : slice_gt;

   // Offset binary: inverting the MSB maps two's complement order onto
   // unsigned order.
   assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      gt_rec_d = gt_rec_q;
      x_d      = x_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d      = a ^ sign_flip;
               b_d      = b ^ sign_flip;
               cnt_d    = '0;
               diff_d   = 1'b0;
               gt_rec_d = 1'b0;
               x_d      = 3'b000;
               state_d  = StCmp;
            end
         end

         StCmp: begin
            a_d   = a_q << DIGIT;
            b_d   = b_q << DIGIT;
            cnt_d = cnt_q + 1'b1;

            // Sticky record of the first difference; later digits never
            // overwrite it.
            if (slice_ne && !diff_q) begin
               diff_d   = 1'b1;
               gt_rec_d = slice_gt;
            end

            if ((slice_ne && EARLY_EXIT) || (cnt_q == LAST_DIG)) begin
               x_d     = any_diff ? (first_gt ? X_GT : X_LT) : X_EQ;
               state_d = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         diff_q   <= 1'b0;
         gt_rec_q <= 1'b0;
         x_q      <= 3'b000;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         gt_rec_q <= gt_rec_d;
         x_q      <= x_d;
      end
   end

   // busy/done are pure state decodes so they drop together with the state on
   // an asynchronous reset.
   assign busy = (state_q == StCmp);
   assign done = (state_q == StDone);
   assign x    = x_q;

endmodule
